// File: rtl/lm96570_spi_pkg.sv
// Shared types, widths and helpers for the LM96570 configuration-port shift engine.
package lm96570_spi_pkg;

  localparam int unsigned DATA_W_DEFAULT = 64;
  localparam int unsigned CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } state_t;

  // A frame length is legal when it is non-zero and fits the shift word.
  function automatic logic n_legal(input logic [7:0] n, input int unsigned max_bits);
    return (n != 8'd0) && (32'(n) <= max_bits);
  endfunction

endpackage

// File: rtl/lm96570_spi_tick.sv
// Half-period divider: counts 0..CLK_DIV-1 and flags the last cycle of each SCLK phase.
module lm96570_spi_tick
  import lm96570_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick_c
);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_W'(CLK_DIV - 32'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lm96570_spi_engine.sv
// LM96570 configuration-port engine: builds the SLE/SCLK/SDATA frame from the PIO
// values and returns the captured readback word.
module lm96570_spi_engine
  import lm96570_spi_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        num_bits,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_sclk,
  output logic              spi_sle,
  output logic              spi_sdo,
  input  logic              spi_sdi
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              busy_d, done_d, err_d, sclk_d, sle_d, sdo_d;
  logic              tick_c, restart_c, last_bit_c;

  // Divider is held at zero in IDLE and restarts on every phase boundary.
  assign restart_c  = (state_q == IDLE) || tick_c;
  assign last_bit_c = (bit_q == (n_q - 8'd1));

  lm96570_spi_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .restart(restart_c),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      spi_sclk <= 1'b0;
      spi_sle  <= 1'b0;
      spi_sdo  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rx_data  <= rx_data_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      spi_sclk <= sclk_d;
      spi_sle  <= sle_d;
      spi_sdo  <= sdo_d;
    end
  end

  // tx_q holds the bits still to be sent after the one currently on spi_sdo.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sclk_d    = spi_sclk;
    sle_d     = spi_sle;
    sdo_d     = spi_sdo;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_legal(num_bits, DATA_W)) begin
            state_d = LEAD;
            n_d     = num_bits;
            bit_d   = 8'd0;
            tx_d    = tx_data >> 1;
            rx_d    = '0;
            busy_d  = 1'b1;
            sle_d   = 1'b1;
            sclk_d  = 1'b0;
            sdo_d   = tx_data[0];
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end

      LEAD: begin
        if (tick_c) begin
          state_d  = SHIFT;
          sclk_d   = 1'b1;
          rx_d[0]  = spi_sdi;
        end
      end

      SHIFT: begin
        if (tick_c) begin
          if (spi_sclk) begin
            sclk_d = 1'b0;
            if (!last_bit_c) begin
              sdo_d = tx_q[0];
              tx_d  = tx_q >> 1;
            end
          end else if (last_bit_c) begin
            state_d = TRAIL;
          end else begin
            bit_d                = bit_q + 8'd1;
            sclk_d               = 1'b1;
            rx_d[IDX_W'(bit_d)]  = spi_sdi;
          end
        end
      end

      TRAIL: begin
        if (tick_c) begin
          state_d   = IDLE;
          sle_d     = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lm96570_spi_engine.sv
// Scoreboard bench for lm96570_spi_engine: H=4 instance for frame tests, H=1 instance for minimum timing.
module tb_lm96570_spi_engine;

  localparam int unsigned DW = 64;
  localparam int H = 4;

  typedef struct {
    logic [DW-1:0] rx;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          start;
  logic [7:0]    num_bits;
  logic [DW-1:0] tx_data;
  logic          busy, done, err;
  logic [DW-1:0] rx_data;
  logic          spi_sclk, spi_sle, spi_sdo, spi_sdi;
  logic          sdi_loop, sdi_tie;

  logic          start1;
  logic [7:0]    num_bits1;
  logic [DW-1:0] tx_data1;
  logic          busy1, done1, err1;
  logic [DW-1:0] rx_data1;
  logic          sclk1, sle1, sdo1;

  assign spi_sdi = sdi_loop ? spi_sdo : sdi_tie;

  lm96570_spi_engine #(.DATA_W(DW), .CLK_DIV(H)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_bits(num_bits), .tx_data(tx_data),
    .busy(busy), .done(done), .err(err), .rx_data(rx_data),
    .spi_sclk(spi_sclk), .spi_sle(spi_sle), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi)
  );

  lm96570_spi_engine #(.DATA_W(DW), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .num_bits(num_bits1), .tx_data(tx_data1),
    .busy(busy1), .done(done1), .err(err1), .rx_data(rx_data1),
    .spi_sclk(sclk1), .spi_sle(sle1), .spi_sdo(sdo1), .spi_sdi(sdo1)
  );

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  int r_busy, r_done, r_done_at, r_rises;
  logic [DW-1:0] r_sdo;

  task automatic run_frame(input logic [7:0] n, input logic [DW-1:0] tx,
                           input logic [DW-1:0] exp_rx, input int second_at, input int window);
    exp_t e;
    logic prev;
    r_busy = 0; r_done = 0; r_done_at = -1; r_rises = 0; r_sdo = '0; prev = 1'b0;
    e.rx = exp_rx; e.err = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    num_bits = n; tx_data = tx; start = 1'b1;
    @(negedge clk);
    start = 1'b0; num_bits = 8'd3; tx_data = ~tx;
    for (int k = 1; k <= window; k++) begin
      if (busy) r_busy++;
      if (spi_sclk && !prev) begin
        if (r_rises < DW) r_sdo[r_rises] = spi_sdo;
        r_rises++;
      end
      prev = spi_sclk;
      if (done) begin
        r_done++;
        if (r_done_at < 0) r_done_at = k;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected_done: done at cycle %0d with nothing expected", k);
        end else begin
          e = exp_q.pop_front();
          if ({err, rx_data} !== {e.err, e.rx}) begin
            miscompares++;
            $display("FAIL sb_frame: got err=%b rx=%h want err=%b rx=%h", err, rx_data, e.err, e.rx);
          end
        end
      end
      start = (k == second_at);
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_missing_done: %0d expected results never produced", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, err, spi_sclk, spi_sle, spi_sdo} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, err, spi_sclk, spi_sle, spi_sdo});
    end
    vectors++;
    if (rx_data !== '0) begin
      miscompares++;
      $display("FAIL reset_rx: got %h want 0", rx_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback_a5();
    int blen;
    blen = (2 * 8 + 2) * H;
    sdi_loop = 1'b1;
    run_frame(8'd8, 64'hA5, 64'hA5, 0, blen + 20);
    vectors++;
    if (r_sdo[7:0] !== 8'hA5) begin
      miscompares++; $display("FAIL a5_sdo_seq: got %b want 10100101 (bit0 first)", r_sdo[7:0]);
    end
    vectors++;
    if (r_rises != 8) begin
      miscompares++; $display("FAIL a5_rises: got %0d want 8", r_rises);
    end
    vectors++;
    if (r_busy != blen) begin
      miscompares++; $display("FAIL a5_busy_len: got %0d want %0d", r_busy, blen);
    end
    vectors++;
    if (r_done != 1 || r_done_at != blen + 1) begin
      miscompares++; $display("FAIL a5_done: got %0d pulses at %0d want 1 at %0d", r_done, r_done_at, blen + 1);
    end
  endtask

  task automatic test_full_width();
    int blen;
    blen = (2 * 64 + 2) * H;
    sdi_loop = 1'b0; sdi_tie = 1'b1;
    run_frame(8'd64, 64'h0123456789ABCDEF, {DW{1'b1}}, 0, blen + 20);
    vectors++;
    if (r_rises != 64) begin
      miscompares++; $display("FAIL full_rises: got %0d want 64", r_rises);
    end
    vectors++;
    if (r_sdo !== 64'h0123456789ABCDEF) begin
      miscompares++; $display("FAIL full_sdo_seq: got %h want 0123456789abcdef", r_sdo);
    end
    vectors++;
    if (r_busy != blen || r_done != 1) begin
      miscompares++; $display("FAIL full_timing: got busy=%0d done=%0d want busy=%0d done=1", r_busy, r_done, blen);
    end
    sdi_tie = 1'b0;
  endtask

  task automatic test_illegal(input logic [7:0] n);
    exp_t e;
    e.rx = rx_data; e.err = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    num_bits = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy, spi_sle, spi_sclk} !== 3'b000 || {done, err} !== 2'b11) begin
      miscompares++;
      $display("FAIL illegal_n%0d_pulse: got busy/sle/sclk=%b done/err=%b want 000 11",
               n, {busy, spi_sle, spi_sclk}, {done, err});
    end
    vectors++;
    e = exp_q.pop_front();
    if ({err, rx_data} !== {e.err, e.rx}) begin
      miscompares++; $display("FAIL illegal_n%0d_rx: got err=%b rx=%h want err=1 rx=%h", n, err, rx_data, e.rx);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, err, spi_sle, spi_sclk} !== 5'b0) begin
      miscompares++; $display("FAIL illegal_n%0d_after: got %b want 00000", n, {busy, done, err, spi_sle, spi_sclk});
    end
  endtask

  task automatic test_back_to_back();
    int blen;
    blen = (2 * 8 + 2) * H;
    sdi_loop = 1'b1;
    run_frame(8'd8, 64'h3C, 64'h3C, 10, blen + 40);
    vectors++;
    if (r_done != 1 || r_busy != blen || r_rises != 8) begin
      miscompares++;
      $display("FAIL b2b_single_frame: got done=%0d busy=%0d rises=%0d want 1 %0d 8", r_done, r_busy, r_rises, blen);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic prev;
    int rises;
    bit found;
    prev = 1'b0; rises = 0; found = 1'b0;
    sdi_loop = 1'b1;
    @(negedge clk);
    num_bits = 8'd16; tx_data = 64'hBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
      if (rises == 4) found = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL midrst_reach_bit3: got %0d rises want 4", rises);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, spi_sclk, spi_sle, spi_sdo} !== 6'b0 || rx_data !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got ctrl=%b rx=%h want 0", {busy, done, err, spi_sclk, spi_sle, spi_sdo}, rx_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midrst_no_done: got done=%b busy=%b want 0 0", done, busy);
    end
    run_frame(8'd4, 64'h6, 64'h6, 0, (2 * 4 + 2) * H + 20);
    vectors++;
    if (r_busy != (2 * 4 + 2) * H || r_done != 1) begin
      miscompares++; $display("FAIL midrst_recover: got busy=%0d done=%0d want %0d 1", r_busy, r_done, (2 * 4 + 2) * H);
    end
  endtask

  task automatic test_h1();
    exp_t e;
    int nb, nd;
    nb = 0; nd = 0;
    e.rx = 64'h1; e.err = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    num_bits1 = 8'd1; tx_data1 = 64'h1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (busy1) nb++;
      if (done1) begin
        nd++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL h1_unexpected_done: cycle %0d", k);
        end else begin
          e = exp_q.pop_front();
          if ({err1, rx_data1} !== {e.err, e.rx}) begin
            miscompares++; $display("FAIL h1_frame: got err=%b rx=%h want err=%b rx=%h", err1, rx_data1, e.err, e.rx);
          end
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (nb != 4 || nd != 1 || {sclk1, sle1} !== 2'b00) begin
      miscompares++; $display("FAIL h1_busy_len: got busy=%0d done=%0d want 4 1", nb, nd);
    end
    exp_q.delete();
  endtask

  initial begin
    start = 1'b0; num_bits = 8'd0; tx_data = '0; sdi_loop = 1'b0; sdi_tie = 1'b0;
    start1 = 1'b0; num_bits1 = 8'd0; tx_data1 = '0;
    test_reset();
    test_loopback_a5();
    test_full_width();
    test_illegal(8'd0);
    test_illegal(8'd65);
    test_back_to_back();
    test_reset_mid_frame();
    test_h1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
